camera_downsampler: RTL and testbench
=====================================

Name: camera_downsampler

Overview:
- Capture stage directly upstream of the frame buffer that feeds the image processor.
- Takes the camera's byte-serial RGB565 stream, with HREF and VSYNC framing, at the camera pixel clock.
- Packs each two-byte pixel into RGB332 and emits one buffer write per pixel, with X/Y addresses clipped to the 176x144 frame.
- Emits a per-frame done pulse; the processor consumes what this block writes.

Parameters:
- SCREEN_WIDTH, 176, pixels per line that may be written; later pixels are dropped.
- SCREEN_HEIGHT, 144, lines per frame that may be written; later lines are dropped.

Ports:
- CLK  input  1  camera pixel clock; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- CAM_DATA  input  8  camera byte; sampled when CAM_HREF=1.
- CAM_HREF  input  1  line-valid from the camera.
- CAM_VSYNC  input  1  frame sync; high between frames.
- PIXEL_OUT  output  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- W_EN  output  1  frame-buffer write strobe, one cycle per pixel.
- X_ADDR  output  10  write column, 0..SCREEN_WIDTH-1.
- Y_ADDR  output  10  write row, 0..SCREEN_HEIGHT-1.
- FRAME_DONE  output  1  one-cycle pulse at end of frame.
- TEST_MODE  input  1  test-pattern select; used only under the optional feature.

Behaviour:
- Reset, asynchronous: all outputs 0, X/Y counters 0, state WAIT_FRAME, byte buffer 0, edge-history registers 0.
- CAM_VSYNC and CAM_HREF are registered once. Edges are detected against the registered copy.
- States:
  - WAIT_FRAME: leave on VSYNC falling edge, go to WAIT_LINE.
  - WAIT_LINE: on HREF=1 capture byte 1, go to SECOND_BYTE.
  - SECOND_BYTE: on HREF=1 form and write the pixel, go to FIRST_BYTE. On HREF=0 discard byte 1 (odd byte) and go to WAIT_LINE.
  - FIRST_BYTE: on HREF=1 capture byte 1, go to SECOND_BYTE. On HREF=0 go to WAIT_LINE.
- Packing: b1 = RRRRRGGG, b2 = GGGBBBBB. PIXEL_OUT = {b1[7:5], b1[2:0], b2[4:3]}.
- Pixel commit:
  - Happens on the cycle the second byte is sampled.
  - PIXEL_OUT, X_ADDR, Y_ADDR and W_EN are registered and valid the following cycle (latency 1).
  - W_EN is high for exactly one cycle.
  - The X counter increments after every commit, including suppressed ones, and saturates at 1023.
- Clipping: if X>=SCREEN_WIDTH or Y>=SCREEN_HEIGHT, W_EN stays 0. PIXEL_OUT and the addresses may still update.
- Line end (HREF falling edge):
  - If at least one pixel was committed on the line, Y increments, saturating at 1023.
  - X clears to 0.
  - A falling edge with zero pixels leaves Y unchanged.
- Frame end (VSYNC rising edge, from any state):
  - FRAME_DONE pulses for one cycle.
  - X and Y clear to 0; state goes to WAIT_FRAME.
  - A half-captured pixel is discarded.
- Simultaneous events:
  - VSYNC rising on the same cycle as a second byte: the pixel is dropped and the frame-end action wins.
  - HREF falling on the same cycle as a commit is impossible by construction, because a commit needs HREF=1.
- Reset mid-line: the partial line is lost. Capture restarts only after the next VSYNC falling edge.

Optional Feature:
- TEST_PATTERN_EN defined:
  - When TEST_MODE=1, the camera bytes are ignored for PIXEL_OUT only; timing, addresses and W_EN still follow the camera framing.
  - PIXEL_OUT is horizontal colour bars by Y: rows 0-47 = 8'hE0 (red), 48-95 = 8'h1C (green), 96-143 = 8'h03 (blue).
- TEST_PATTERN_EN undefined: TEST_MODE is ignored and no pattern logic is synthesised.

Test Plan:
- Single pixel: VSYNC 1->0, HREF=1, bytes 8'hF8, 8'h1F -> one cycle after the second byte: W_EN=1, PIXEL_OUT=8'hE3, X_ADDR=0, Y_ADDR=0.
- Full frame: 144 lines of 176 pixels (352 bytes each) -> exactly 25344 W_EN pulses, last at X=175, Y=143. Then VSYNC rising -> FRAME_DONE for 1 cycle; X=Y=0.
- Clipping: 180-pixel lines, 150 lines -> still 25344 writes; no W_EN for X>=176 or Y>=144.
- Odd byte: HREF high for 3 bytes (8'hFF, 8'hFF, 8'h12), then low -> one write PIXEL_OUT=8'hFF; 8'h12 discarded; next line starts at X=0, Y=1.
- Reset: assert RESET_N=0 asynchronously mid-line -> all outputs 0 immediately. HREF activity before the next VSYNC falling edge -> no W_EN.
- With TEST_PATTERN_EN and TEST_MODE=1, full frame -> line 0 pixels 8'hE0, line 50 pixels 8'h1C, line 100 pixels 8'h03.

Source files
------------

// File: rtl/camera_downsampler.sv
// ============================================================================
// Module   : camera_downsampler
// Purpose  : Byte-serial RGB565 camera capture -> RGB332 frame-buffer writes
//            with X/Y addresses clipped to SCREEN_WIDTH x SCREEN_HEIGHT.
// Option   : define TEST_PATTERN_EN to enable horizontal colour bars when
//            TEST_MODE=1 (framing still follows the camera).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module camera_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] CAM_DATA,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  input  logic       TEST_MODE,
  output logic [7:0] PIXEL_OUT,
  output logic       W_EN,
  output logic [9:0] X_ADDR,
  output logic [9:0] Y_ADDR,
  output logic       FRAME_DONE
);

  typedef enum logic [1:0] {
    WAIT_FRAME  = 2'd0,
    WAIT_LINE   = 2'd1,
    SECOND_BYTE = 2'd2,
    FIRST_BYTE  = 2'd3
  } state_t;

  localparam logic [9:0] C_CNT_MAX = 10'd1023;
  localparam logic [9:0] C_WIDTH   = 10'(SCREEN_WIDTH);
  localparam logic [9:0] C_HEIGHT  = 10'(SCREEN_HEIGHT);

  state_t     state_q, state_d;
  logic       vsync_q, vsync_d;
  logic       href_q, href_d;
  logic [7:0] byte1_q, byte1_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       line_pix_q, line_pix_d;
  logic [7:0] pixel_out_q, pixel_out_d;
  logic       w_en_q, w_en_d;
  logic [9:0] x_addr_q, x_addr_d;
  logic [9:0] y_addr_q, y_addr_d;
  logic       frame_done_q, frame_done_d;

  logic       w_vsync_rise;
  logic       w_vsync_fall;
  logic       w_href_fall;
  logic [7:0] w_pixel;

  // Edges are taken between the live input and its one-cycle-old copy.
  always_comb begin
    w_vsync_rise = CAM_VSYNC & ~vsync_q;
    w_vsync_fall = ~CAM_VSYNC & vsync_q;
    w_href_fall  = ~CAM_HREF & href_q;
  end

`ifdef TEST_PATTERN_EN
  // Pixel source: colour bars by current row in test mode, else RGB565 -> RGB332.
  always_comb begin
    if (TEST_MODE) begin
      if (y_q < 10'd48)      w_pixel = 8'hE0;
      else if (y_q < 10'd96) w_pixel = 8'h1C;
      else                   w_pixel = 8'h03;
    end else begin
      w_pixel = {byte1_q[7:5], byte1_q[2:0], CAM_DATA[4:3]};
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = TEST_MODE;

  // Pixel source: top bits of R, G and B from the two RGB565 bytes.
  always_comb begin
    w_pixel = {byte1_q[7:5], byte1_q[2:0], CAM_DATA[4:3]};
  end
`endif

  // Next-state logic: capture FSM, X/Y counters and the registered write port.
  always_comb begin
    state_d      = state_q;
    vsync_d      = CAM_VSYNC;
    href_d       = CAM_HREF;
    byte1_d      = byte1_q;
    x_d          = x_q;
    y_d          = y_q;
    line_pix_d   = line_pix_q;
    pixel_out_d  = pixel_out_q;
    w_en_d       = 1'b0;
    x_addr_d     = x_addr_q;
    y_addr_d     = y_addr_q;
    frame_done_d = 1'b0;

    if (w_vsync_rise) begin
      // Frame end overrides everything, including a second byte this cycle.
      frame_done_d = 1'b1;
      x_d          = 10'd0;
      y_d          = 10'd0;
      line_pix_d   = 1'b0;
      state_d      = WAIT_FRAME;
    end else begin
      // A line only advances Y if it produced at least one pixel.
      if (w_href_fall) begin
        x_d        = 10'd0;
        line_pix_d = 1'b0;
        if (line_pix_q && (y_q != C_CNT_MAX)) begin
          y_d = y_q + 10'd1;
        end
      end

      case (state_q)
        WAIT_FRAME: begin
          if (w_vsync_fall) state_d = WAIT_LINE;
        end
        WAIT_LINE, FIRST_BYTE: begin
          if (CAM_HREF) begin
            byte1_d = CAM_DATA;
            state_d = SECOND_BYTE;
          end else begin
            state_d = WAIT_LINE;
          end
        end
        SECOND_BYTE: begin
          if (CAM_HREF) begin
            pixel_out_d = w_pixel;
            x_addr_d    = x_q;
            y_addr_d    = y_q;
            w_en_d      = (x_q < C_WIDTH) && (y_q < C_HEIGHT);
            line_pix_d  = 1'b1;
            if (x_q != C_CNT_MAX) x_d = x_q + 10'd1;
            state_d     = FIRST_BYTE;
          end else begin
            // Odd trailing byte: drop it.
            state_d = WAIT_LINE;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= WAIT_FRAME;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte1_q      <= 8'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      line_pix_q   <= 1'b0;
      pixel_out_q  <= 8'd0;
      w_en_q       <= 1'b0;
      x_addr_q     <= 10'd0;
      y_addr_q     <= 10'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      byte1_q      <= byte1_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_pix_q   <= line_pix_d;
      pixel_out_q  <= pixel_out_d;
      w_en_q       <= w_en_d;
      x_addr_q     <= x_addr_d;
      y_addr_q     <= y_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign PIXEL_OUT  = pixel_out_q;
  assign W_EN       = w_en_q;
  assign X_ADDR     = x_addr_q;
  assign Y_ADDR     = y_addr_q;
  assign FRAME_DONE = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_camera_downsampler.sv
// ============================================================================
// Module   : tb_camera_downsampler
// Purpose  : Scoreboard bench for camera_downsampler. The driver pushes the
//            expected buffer write for every pixel it sends; a monitor pops
//            and compares on every W_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_camera_downsampler;

  typedef struct packed {
    logic [7:0] p;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] cam_data;
  logic       cam_href;
  logic       cam_vsync;
  logic       test_mode;
  logic [7:0] pixel_out;
  logic       w_en;
  logic [9:0] x_addr;
  logic [9:0] y_addr;
  logic       frame_done;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   w_cnt   = 0;
  int   fd_cnt  = 0;
  int   exp_fd  = 0;
  logic fd_prev = 1'b0;

  camera_downsampler #(.SCREEN_WIDTH(176), .SCREEN_HEIGHT(144)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .CAM_DATA   (cam_data),
    .CAM_HREF   (cam_href),
    .CAM_VSYNC  (cam_vsync),
    .TEST_MODE  (test_mode),
    .PIXEL_OUT  (pixel_out),
    .W_EN       (w_en),
    .X_ADDR     (x_addr),
    .Y_ADDR     (y_addr),
    .FRAME_DONE (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack(input logic [7:0] b1, input logic [7:0] b2,
                                      input logic [9:0] y);
`ifdef TEST_PATTERN_EN
    if (test_mode) return (y < 10'd48) ? 8'hE0 : (y < 10'd96) ? 8'h1C : 8'h03;
`endif
    if (y == 10'h3FF) return 8'h00;  // keeps y referenced in every build
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (vs && !cam_vsync) exp_fd++;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(cam_vsync, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] p, input int x, input int y);
    exp_t e;
    e.p = p;
    e.x = 10'(x);
    e.y = 10'(y);
    q.push_back(e);
  endtask

  task automatic start_frame();
    cyc(1'b1, 1'b0, 8'h00);
    idle(2);
    cyc(1'b0, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic end_frame(input string name);
    idle(2);
    cyc(1'b1, 1'b0, 8'h00);
    idle(3);
    check(name, fd_cnt, exp_fd);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check(name, q.size(), 0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      n_tests++;
      if (fd_prev) begin
        n_fail++;
        $display("FAIL fd_width: FRAME_DONE high two cycles, expected one");
      end
    end
    fd_prev = frame_done;
    if (w_en) begin
      w_cnt++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wen: write pix=%0h x=%0d y=%0d, expected none",
                 pixel_out, x_addr, y_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pixel_out !== e.p || x_addr !== e.x || y_addr !== e.y) begin
          n_fail++;
          $display("FAIL write: got pix=%0h x=%0d y=%0d, expected pix=%0h x=%0d y=%0d",
                   pixel_out, x_addr, y_addr, e.p, e.x, e.y);
        end
      end
    end
  end

  initial begin
    int w0;
    rst_n     = 1'b0;
    cam_data  = 8'h00;
    cam_href  = 1'b0;
    cam_vsync = 1'b0;
    test_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_wen", int'(w_en), 0);
    check("rst_x", int'(x_addr), 0);
    check("rst_y", int'(y_addr), 0);
    check("rst_fd", int'(frame_done), 0);
    rst_n = 1'b1;

    // Single pixel: F8,1F -> E3 at (0,0)
    start_frame();
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b0, 1'b1, 8'h1F); push(8'hE3, 0, 0);
    cyc(1'b0, 1'b0, 8'h00);
    drain("single_drain");
    end_frame("single_fd");

    // Odd byte, empty line, following lines
    start_frame();
    cyc(1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 8'hFF); push(8'hFF, 0, 0);
    cyc(1'b0, 1'b1, 8'h12);
    idle(2);
    cyc(1'b0, 1'b1, 8'hAB);
    cyc(1'b0, 1'b1, 8'hCD); push(8'hAD, 0, 1);
    idle(2);
    cyc(1'b0, 1'b1, 8'h77);                 // lone byte: no pixel, Y stays
    idle(2);
    cyc(1'b0, 1'b1, 8'h12);
    cyc(1'b0, 1'b1, 8'h34); push(8'h0A, 0, 2);
    idle(2);
    drain("odd_drain");
    end_frame("odd_fd");

    // Full frame with clipping: 150 lines of 180 pixels
`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
`endif
    w0 = w_cnt;
    start_frame();
    for (int l = 0; l < 150; l++) begin
      for (int p = 0; p < 180; p++) begin
        logic [7:0] b1, b2;
        b1 = 8'(l * 7 + p);
        b2 = 8'(p * 3 + l);
        cyc(1'b0, 1'b1, b1);
        cyc(1'b0, 1'b1, b2);
        if (p < 176 && l < 144) push(pack(b1, b2, 10'(l)), p, l);
      end
      idle(2);
    end
    drain("frame_drain");
    check("frame_writes", w_cnt - w0, 25344);
    end_frame("frame_fd");
    test_mode = 1'b0;

    // Counters cleared; then VSYNC rising with a second byte drops the pixel
    start_frame();
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h18); push(8'h03, 0, 0);
    cyc(1'b0, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 8'h66);
    cyc(1'b1, 1'b0, 8'h00);
    idle(3);
    drain("simul_drain");
    check("simul_fd", fd_cnt, exp_fd);

    // Asynchronous reset mid-line
    start_frame();
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b1, 8'h22); push(pack(8'h11, 8'h22, 10'd0), 0, 0);
    cyc(1'b0, 1'b1, 8'h33);
    cyc(1'b0, 1'b1, 8'h44); push(pack(8'h33, 8'h44, 10'd0), 1, 0);
    cyc(1'b0, 1'b1, 8'h55);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pixel", int'(pixel_out), 0);
    check("arst_wen", int'(w_en), 0);
    check("arst_x", int'(x_addr), 0);
    check("arst_y", int'(y_addr), 0);
    check("arst_fd", int'(frame_done), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    w0 = w_cnt;
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 8; b++) cyc(1'b0, 1'b1, 8'(b + 1));
      idle(2);
    end
    check("arst_no_wen", w_cnt - w0, 0);
    drain("arst_drain");
    cyc(1'b1, 1'b0, 8'h00);
    idle(3);
    check("arst_fd_after", fd_cnt, exp_fd);
    cyc(1'b0, 1'b0, 8'h00);
    idle(2);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h18); push(8'h03, 0, 0);
    idle(2);
    drain("restart_drain");
    end_frame("final_fd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
